serial_slice_compare: RTL

- Multi-cycle sequencer that compares two wide unsigned operands using the team's 3-bit cascadable comparator stage.
- Sits directly around that stage. It feeds one 3-bit slice per cycle, LSB slice first, together with the cascade inputs (G, E, L). It then registers the stage's L_T/G_T/E_Q back as the cascade inputs for the next slice.
- After SLICES cycles it presents the final greater/equal/less verdict with a done pulse.

---
 rtl/serial_compare_pkg.sv | 23 ++
 rtl/slice_select.sv | 20 ++
 rtl/serial_slice_compare.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serial_compare_pkg.sv
// Shared types and constants for the bit-serial (slice-serial) magnitude comparator.
package serial_compare_pkg;

   localparam int SLICE_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   typedef struct packed {
      logic g;
      logic e;
      logic l;
   } casc_t;

   localparam casc_t CASC_INIT = '{g: 1'b0, e: 1'b1, l: 1'b0};

   function automatic logic casc_onehot(casc_t c);
      return (c == 3'b100) || (c == 3'b010) || (c == 3'b001);
   endfunction

endpackage

// File: rtl/slice_select.sv
// Pure mux: returns the SLICE_W-bit slice number idx_i of a SLICES-slice vector.
module slice_select
   import serial_compare_pkg::*;
#(
   parameter int SLICES = 4,
   parameter int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1
) (
   input  logic [SLICE_W*SLICES-1:0] vec_i,
   input  logic [IDX_W-1:0]          idx_i,
   output logic [SLICE_W-1:0]        slice_o
);

   always_comb begin
      slice_o = '0;
      for (int s = 0; s < SLICES; s++) begin
         if (idx_i == IDX_W'(s)) slice_o = vec_i[s*SLICE_W +: SLICE_W];
      end
   end

endmodule

// File: rtl/serial_slice_compare.sv
// Sequencer around an external 3-bit cascadable comparator: one slice per cycle, LSB first.
module serial_slice_compare
   import serial_compare_pkg::*;
#(
   parameter int SLICES = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [SLICE_W*SLICES-1:0] a,
   input  logic [SLICE_W*SLICES-1:0] b,
   output logic                      busy,
   output logic                      done,
   output logic                      a_gt_b,
   output logic                      a_eq_b,
   output logic                      a_lt_b,
   output logic                      err,
   output logic [SLICE_W-1:0]        cmp_a,
   output logic [SLICE_W-1:0]        cmp_b,
   output logic                      cmp_g,
   output logic                      cmp_e,
   output logic                      cmp_l,
   input  logic                      cmp_lt,
   input  logic                      cmp_gt,
   input  logic                      cmp_eq
);

   localparam int W     = SLICE_W * SLICES;
   localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(SLICES - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d;
   casc_t            casc_q, casc_d, stage;
   logic             done_q, done_d;
   logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
   logic             err_q, err_d;

   assign stage = '{g: cmp_gt, e: cmp_eq, l: cmp_lt};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         casc_q  <= CASC_INIT;
         done_q  <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         casc_q  <= casc_d;
         done_q  <= done_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      casc_d  = casc_q;
      done_d  = 1'b0;
      gt_d    = gt_q;
      eq_d    = eq_q;
      lt_d    = lt_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               idx_d   = '0;
               casc_d  = CASC_INIT;
               err_d   = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            casc_d = stage;
            if (!casc_onehot(stage)) err_d = 1'b1;
            if (idx_q != LAST) begin
               idx_d = idx_q + 1'b1;
            end else begin
               gt_d    = stage.g;
               eq_d    = stage.e;
               lt_d    = stage.l;
               done_d  = 1'b1;
               // Park on slice 0 with the initial cascade so IDLE drive is predictable.
               idx_d   = '0;
               casc_d  = CASC_INIT;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   slice_select #(.SLICES(SLICES), .IDX_W(IDX_W)) u_sel_a (
      .vec_i(a_q), .idx_i(idx_q), .slice_o(cmp_a)
   );

   slice_select #(.SLICES(SLICES), .IDX_W(IDX_W)) u_sel_b (
      .vec_i(b_q), .idx_i(idx_q), .slice_o(cmp_b)
   );

   assign busy   = (state_q == RUN);
   assign done   = done_q;
   assign a_gt_b = gt_q;
   assign a_eq_b = eq_q;
   assign a_lt_b = lt_q;
   assign err    = err_q;
   assign cmp_g  = casc_q.g;
   assign cmp_e  = casc_q.e;
   assign cmp_l  = casc_q.l;

endmodule
